mp_add_seq: RTL and testbench



---
 rtl/mp_add_pkg.sv | 19 +
 rtl/ahead_adder16.sv | 49 ++++
 rtl/mp_add_seq.sv | 130 +++++++++++++
 tb/tb_mp_add_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add/sub sequencer.
package mp_add_pkg;

    localparam int W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [W-1:0] word_t;

    // Signed overflow: operands agree in sign but the sum's sign differs.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/ahead_adder16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a group-level carry chain.
module ahead_adder16
    import mp_add_pkg::*;
(
    input  word_t A,
    input  word_t B,
    input  logic  CIN,
    output word_t S,
    output logic  cout
);

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W:0]   w_c;
    logic [3:0]   w_gg;
    logic [3:0]   w_gp;
    logic [4:0]   w_gc;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Group generate/propagate, inter-group carries and per-bit carries.
    always_comb begin
        w_gg    = 4'd0;
        w_gp    = 4'd0;
        w_gc    = 5'd0;
        w_c     = '0;
        w_gc[0] = CIN;
        for (int j = 0; j < 4; j++) begin
            w_gg[j] = w_g[4*j+3]
                    | (w_p[4*j+3] & w_g[4*j+2])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
            w_gp[j]     = &w_p[4*j +: 4];
            w_gc[j+1]   = w_gg[j] | (w_gp[j] & w_gc[j]);
            w_c[4*j]    = w_gc[j];
            w_c[4*j+1]  = w_g[4*j] | (w_p[4*j] & w_gc[j]);
            w_c[4*j+2]  = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                        | (w_p[4*j+1] & w_p[4*j] & w_gc[j]);
            w_c[4*j+3]  = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                        | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                        | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_gc[j]);
        end
        w_c[W] = w_gc[4];
        S      = w_p ^ w_c[W-1:0];
        cout   = w_c[W];
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/sub sequencer: one word per cycle through a shared 16-bit CLA.
// Optional feature macro: MP_ADD_SUB_EN (enables A-B via the sub input).
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W*WORDS-1:0] op_a,
    input  logic [W*WORDS-1:0] op_b,
    input  logic               cin,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*WORDS-1:0] result,
    output logic               cout,
    output logic               ovf
);

    localparam int N    = W * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    state_t          r_state;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_sub;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [N-1:0]    r_result;
    logic            r_cout;
    logic            r_ovf;

    word_t w_a_word;
    word_t w_b_word;
    word_t w_sum;
    logic  w_cout;
    logic  w_sub_req;

`ifdef MP_ADD_SUB_EN
    assign w_sub_req = sub;
`else
    // Port kept for interface compatibility; addition only in this build.
    assign w_sub_req = 1'b0 & sub;
`endif

    assign w_a_word = r_a[r_idx*W +: W];
    assign w_b_word = r_b[r_idx*W +: W] ^ {W{r_sub}};

    ahead_adder16 u_adder (
        .A    (w_a_word),
        .B    (w_b_word),
        .CIN  (r_carry),
        .S    (w_sum),
        .cout (w_cout)
    );

    // Sequencer FSM: accept, walk words LSW first with carry chaining, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= op_a;
                        r_b        <= op_b;
                        r_sub      <= w_sub_req;
                        r_carry    <= w_sub_req ? 1'b1 : cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_result[r_idx*W +: W] <= w_sum;
                    r_carry                <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_cout;
                        r_ovf       <= add_ovf(w_a_word[W-1], w_b_word[W-1], w_sum[W-1]);
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    // in_ready returns one cycle after the handshake, never in the same cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (WORDS=4) against an arithmetic reference model.
module tb_mp_add_seq;

    localparam int WORDS = 4;
    localparam int N     = 16 * WORDS;
    localparam int NOPS  = 3000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] op_a = '0;
    logic [N-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] g_res;
    logic         g_c;
    logic         g_o;

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full operand width.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                         input logic sb, output logic [N-1:0] r, output logic c, output logic o);
        logic        do_sub;
        logic [N:0]  full;
        logic signed [N:0] sa;
        logic signed [N:0] sbv;
        logic signed [N:0] sres;
`ifdef MP_ADD_SUB_EN
        do_sub = sb;
`else
        do_sub = 1'b0;
`endif
        sa  = $signed({a[N-1], a});
        sbv = $signed({b[N-1], b});
        if (do_sub) begin
            r    = a - b;
            c    = (a >= b);
            sres = sa - sbv;
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
            r    = full[N-1:0];
            c    = full[N];
            sres = sa + sbv + $signed({{N{1'b0}}, ci});
        end
        o = (sres[N] != sres[N-1]);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                          input logic sb, input int hold, input bit scramble, input bit chk_lat,
                          input bit poke);
        logic [N-1:0] er;
        logic         ec;
        logic         eo;
        int           cnt;
        model(a, b, ci, sb, er, ec, eo);
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        check_eq("in_ready_wait", in_ready, 1);
        op_a = a; op_b = b; cin = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            if (scramble) begin
                op_a     = {$urandom, $urandom};
                op_b     = {$urandom, $urandom};
                cin      = 1'($urandom);
                sub      = 1'($urandom);
                in_valid = 1'($urandom);
            end
            @(posedge clk); #1; cnt++;
        end
        in_valid = 1'b0;
        check_eq("out_valid_rise", out_valid, 1);
        if (chk_lat) check_eq("latency", cnt, WORDS);
        check_eq("result", result, er);
        check_eq("cout", cout, ec);
        check_eq("ovf", ovf, eo);
        g_res = result; g_c = cout; g_o = ovf;
        for (int i = 0; i < hold; i++) begin
            in_valid = (poke && i == 2);
            op_a     = ~a;
            @(posedge clk); #1;
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_in_ready", in_ready, 0);
            check_eq("hold_result", result, er);
            check_eq("hold_flags", {cout, ovf}, {ec, eo});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("post_hs_valid", out_valid, 0);
        check_eq("post_hs_ready", in_ready, 1);
        if (poke) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            check_eq("dropped_pulse", {in_ready, out_valid}, 2'b10);
        end
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        // Reset state
        #12;
        check_eq("rst_ready", in_ready, 1);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_out", {result, cout, ovf}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: full carry ripple through every word
        run_op({N{1'b1}}, 64'd1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        check_eq("t1_const", {g_c, g_o, g_res}, {1'b1, 1'b0, 64'h0});

        // 2: positive overflow
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        check_eq("t2_const", {g_c, g_o, g_res}, {1'b0, 1'b1, 64'h8000_0000_0000_0000});

        // 3: 0 - 1 (or 0 + 1 when subtraction is not built in)
        run_op(64'd0, 64'd1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
`ifdef MP_ADD_SUB_EN
        check_eq("t3_const", {g_c, g_o, g_res}, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
`else
        check_eq("t3_const", {g_c, g_o, g_res}, {1'b0, 1'b0, 64'h1});
`endif

        // 4: back-pressure in DONE with a stray in_valid pulse
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 6, 1'b0, 1'b1, 1'b1);

        // 5: reset during RUN
        op_a = 64'h0000_0000_0001_0001; op_b = 64'h0000_0000_0002_0002; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_result", result, 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("postrst_ready", in_ready, 1);
        run_op(64'hAAAA_5555_AAAA_5555, 64'h5555_AAAA_5555_AAAB, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);

        // 6: randomized traffic with gaps and input scrambling while busy
        for (int n = 0; n < NOPS; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n % 16 == 0) ra[N-1] = ~rb[N-1];
            if (n % 23 == 0) rb = ~ra;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge clk); #1;
            end
            run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b1, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
